// File: rtl/id_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : id_branch_resolve_unit
// Brief    : ID-stage branch resolver with forwarding muxes, operand-wait FSM,
//            sticky timeout flag and saturating taken-branch counter.
// Revision : 1.0
// ============================================================================
module id_branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Flush_ID,
    input  logic                  Branch_Valid_ID,
    input  logic [2:0]            Branch_Op_ID,
    input  logic [DATA_WIDTH-1:0] Read_Data_1_ID,
    input  logic [DATA_WIDTH-1:0] Read_Data_2_ID,
    input  logic [DATA_WIDTH-1:0] Fwd_Data_MEM,
    input  logic [DATA_WIDTH-1:0] Write_Data_WB,
    input  logic [1:0]            Forward_C_ID,
    input  logic [1:0]            Forward_D_ID,
    output logic                  Stall_ID,
    output logic                  Resolve_Valid,
    output logic                  Branch_Taken,
    output logic                  Timeout_Err,
    output logic [CNT_WIDTH-1:0]  Taken_Count
);

    localparam logic [0:0]           c_ST_IDLE  = 1'b0;
    localparam logic [0:0]           c_ST_WAIT  = 1'b1;
    localparam logic [7:0]           c_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;

    localparam logic [2:0] c_OP_BEQ  = 3'b000;
    localparam logic [2:0] c_OP_BNE  = 3'b001;
    localparam logic [2:0] c_OP_BLEZ = 3'b010;
    localparam logic [2:0] c_OP_BGTZ = 3'b011;
    localparam logic [2:0] c_OP_BLTZ = 3'b100;
    localparam logic [2:0] c_OP_BGEZ = 3'b101;

    logic [0:0]            r_state;
    logic [2:0]            r_op;
    logic [7:0]            r_cnt;

    logic [2:0]            w_op;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic                  w_need_a;
    logic                  w_need_b;
    logic                  w_ready;
    logic                  w_cond;
    logic                  w_a_zero;
    logic                  w_a_neg;
    logic                  w_timeout;
    logic                  w_resolve;
    logic                  w_taken_next;

    // While waiting, the captured opcode is authoritative; ID may have moved on.
    assign w_op = (r_state == c_ST_WAIT) ? r_op : Branch_Op_ID;

    always_comb begin
        w_op_a = Read_Data_1_ID;
        case (Forward_C_ID)
            2'b01:   w_op_a = Fwd_Data_MEM;
            2'b10:   w_op_a = Write_Data_WB;
            default: w_op_a = Read_Data_1_ID;
        endcase
    end

    always_comb begin
        w_op_b = Read_Data_2_ID;
        case (Forward_D_ID)
            2'b01:   w_op_b = Fwd_Data_MEM;
            2'b10:   w_op_b = Write_Data_WB;
            default: w_op_b = Read_Data_2_ID;
        endcase
    end

    assign w_need_a = (w_op <= c_OP_BGEZ);
    assign w_need_b = (w_op == c_OP_BEQ) || (w_op == c_OP_BNE);
    assign w_ready  = (!w_need_a || (Forward_C_ID != 2'b11)) &&
                      (!w_need_b || (Forward_D_ID != 2'b11));

    assign w_a_zero = (w_op_a == '0);
    assign w_a_neg  = w_op_a[DATA_WIDTH-1];

    always_comb begin
        w_cond = 1'b0;
        case (w_op)
            c_OP_BEQ:  w_cond = (w_op_a == w_op_b);
            c_OP_BNE:  w_cond = (w_op_a != w_op_b);
            c_OP_BLEZ: w_cond = w_a_neg || w_a_zero;
            c_OP_BGTZ: w_cond = !w_a_neg && !w_a_zero;
            c_OP_BLTZ: w_cond = w_a_neg;
            c_OP_BGEZ: w_cond = !w_a_neg;
            default:   w_cond = 1'b0;
        endcase
    end

    assign w_timeout = (r_state == c_ST_WAIT) && !w_ready && (r_cnt == c_MAX_WAIT);

    // A timeout still produces a result pulse, forced to not-taken.
    assign w_resolve = !Flush_ID &&
                       (((r_state == c_ST_IDLE) && Branch_Valid_ID && w_ready) ||
                        ((r_state == c_ST_WAIT) && w_ready) ||
                        w_timeout);
    assign w_taken_next = w_ready && w_cond;

    assign Stall_ID = !Flush_ID &&
                      (((r_state == c_ST_IDLE) && Branch_Valid_ID && !w_ready) ||
                       ((r_state == c_ST_WAIT) && !w_ready && (r_cnt < c_MAX_WAIT)));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_ST_IDLE;
            r_op    <= 3'b000;
            r_cnt   <= 8'd0;
        end else if (Flush_ID) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (Branch_Valid_ID && !w_ready) begin
                        r_op    <= Branch_Op_ID;
                        r_cnt   <= 8'd1;
                        r_state <= c_ST_WAIT;
                    end
                end
                default: begin
                    if (w_ready || w_timeout) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Resolve_Valid <= 1'b0;
            Branch_Taken  <= 1'b0;
            Timeout_Err   <= 1'b0;
            Taken_Count   <= '0;
        end else begin
            Resolve_Valid <= w_resolve;
            if (w_resolve) begin
                Branch_Taken <= w_taken_next;
            end
            if (w_resolve && w_taken_next && (Taken_Count != c_CNT_MAX)) begin
                Taken_Count <= Taken_Count + 1'b1;
            end
            if (w_timeout && !Flush_ID) begin
                Timeout_Err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_branch_resolve_unit
// Brief    : Directed self-checking bench for id_branch_resolve_unit.
// Revision : 1.0
// ============================================================================
module tb_id_branch_resolve_unit;

    logic        Clk;
    logic        Reset_n;
    logic        Flush_ID;
    logic        Branch_Valid_ID;
    logic [2:0]  Branch_Op_ID;
    logic [31:0] Read_Data_1_ID;
    logic [31:0] Read_Data_2_ID;
    logic [31:0] Fwd_Data_MEM;
    logic [31:0] Write_Data_WB;
    logic [1:0]  Forward_C_ID;
    logic [1:0]  Forward_D_ID;
    logic        Stall_ID,  Resolve_Valid,  Branch_Taken,  Timeout_Err;
    logic [15:0] Taken_Count;
    logic        Stall_ID2, Resolve_Valid2, Branch_Taken2, Timeout_Err2;
    logic [1:0]  Taken_Count2;

    int n_checks;
    int n_fail;

    id_branch_resolve_unit #(.DATA_WIDTH(32), .MAX_WAIT(4), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Flush_ID(Flush_ID),
        .Branch_Valid_ID(Branch_Valid_ID), .Branch_Op_ID(Branch_Op_ID),
        .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
        .Fwd_Data_MEM(Fwd_Data_MEM), .Write_Data_WB(Write_Data_WB),
        .Forward_C_ID(Forward_C_ID), .Forward_D_ID(Forward_D_ID),
        .Stall_ID(Stall_ID), .Resolve_Valid(Resolve_Valid),
        .Branch_Taken(Branch_Taken), .Timeout_Err(Timeout_Err),
        .Taken_Count(Taken_Count)
    );

    id_branch_resolve_unit #(.DATA_WIDTH(32), .MAX_WAIT(4), .CNT_WIDTH(2)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .Flush_ID(Flush_ID),
        .Branch_Valid_ID(Branch_Valid_ID), .Branch_Op_ID(Branch_Op_ID),
        .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
        .Fwd_Data_MEM(Fwd_Data_MEM), .Write_Data_WB(Write_Data_WB),
        .Forward_C_ID(Forward_C_ID), .Forward_D_ID(Forward_D_ID),
        .Stall_ID(Stall_ID2), .Resolve_Valid(Resolve_Valid2),
        .Branch_Taken(Branch_Taken2), .Timeout_Err(Timeout_Err2),
        .Taken_Count(Taken_Count2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Registered outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({Resolve_Valid, Branch_Taken, Timeout_Err, Stall_ID} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {Resolve_Valid, Branch_Taken, Timeout_Err, Stall_ID});
        end
        n_checks++;
        if (Taken_Count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", Taken_Count);
        end
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b000; Forward_C_ID = 2'b11;
        #1;
        n_checks++;
        if (Stall_ID !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_comb: got %b expected 1", Stall_ID);
        end
        Branch_Valid_ID = 1'b0; Forward_C_ID = 2'b00;
        Reset_n = 1'b1;
    endtask

    task automatic test_beq_regfile();
        tick();
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b000;
        Read_Data_1_ID = 32'h0000_1234; Read_Data_2_ID = 32'h0000_1234;
        Forward_C_ID = 2'b00; Forward_D_ID = 2'b00;
        #1;
        n_checks++;
        if (Stall_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_stall: got %b expected 0", Stall_ID);
        end
        tick();
        Branch_Valid_ID = 1'b0;
        n_checks++;
        if ({Resolve_Valid, Branch_Taken} !== 2'b11 || Taken_Count !== 16'd1) begin
            n_fail++;
            $display("FAIL beq_result: got rv/bt=%b cnt=%0d expected 11 cnt=1", {Resolve_Valid, Branch_Taken}, Taken_Count);
        end
    endtask

    task automatic test_forward_back_to_back();
        tick();
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b001;
        Read_Data_1_ID = 32'h0; Read_Data_2_ID = 32'h0;
        Fwd_Data_MEM = 32'h5; Write_Data_WB = 32'h5;
        Forward_C_ID = 2'b01; Forward_D_ID = 2'b10;
        tick();
        n_checks++;
        if ({Resolve_Valid, Branch_Taken} !== 2'b10) begin
            n_fail++;
            $display("FAIL bne_fwd: got rv/bt=%b expected 10", {Resolve_Valid, Branch_Taken});
        end
        Branch_Op_ID = 3'b011; Read_Data_1_ID = 32'h8000_0000; Forward_C_ID = 2'b00;
        tick();
        n_checks++;
        if ({Resolve_Valid, Branch_Taken} !== 2'b10) begin
            n_fail++;
            $display("FAIL bgtz_neg: got rv/bt=%b expected 10", {Resolve_Valid, Branch_Taken});
        end
        Branch_Op_ID = 3'b101; Read_Data_1_ID = 32'h0;
        tick();
        n_checks++;
        if ({Resolve_Valid, Branch_Taken} !== 2'b11 || Taken_Count !== 16'd2) begin
            n_fail++;
            $display("FAIL bgez_zero: got rv/bt=%b cnt=%0d expected 11 cnt=2", {Resolve_Valid, Branch_Taken}, Taken_Count);
        end
        Branch_Valid_ID = 1'b0;
        tick();
        n_checks++;
        if ({Resolve_Valid, Branch_Taken} !== 2'b01) begin
            n_fail++;
            $display("FAIL taken_hold: got rv/bt=%b expected 01", {Resolve_Valid, Branch_Taken});
        end
    endtask

    task automatic test_reserved();
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b110;
        Forward_C_ID = 2'b11; Forward_D_ID = 2'b11;
        #1;
        n_checks++;
        if (Stall_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved_stall: got %b expected 0", Stall_ID);
        end
        tick();
        Branch_Valid_ID = 1'b0; Forward_C_ID = 2'b00; Forward_D_ID = 2'b00;
        n_checks++;
        if ({Resolve_Valid, Branch_Taken} !== 2'b10 || Taken_Count !== 16'd2) begin
            n_fail++;
            $display("FAIL reserved_result: got rv/bt=%b cnt=%0d expected 10 cnt=2", {Resolve_Valid, Branch_Taken}, Taken_Count);
        end
    endtask

    task automatic test_wait_ready();
        logic exp_stall [3];
        exp_stall = '{1'b1, 1'b1, 1'b0};
        tick();
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b000;
        Read_Data_2_ID = 32'h7; Fwd_Data_MEM = 32'h7; Read_Data_1_ID = 32'h0;
        Forward_C_ID = 2'b11; Forward_D_ID = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                Branch_Valid_ID = 1'b0;
                Branch_Op_ID    = 3'b001;
            end
            if (i == 2) Forward_C_ID = 2'b01;
            #1;
            n_checks++;
            if (Stall_ID !== exp_stall[i] || Resolve_Valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_stall[%0d]: got stall=%b rv=%b expected stall=%b rv=0", i, Stall_ID, Resolve_Valid, exp_stall[i]);
            end
            tick();
        end
        Branch_Op_ID = 3'b000;
        n_checks++;
        if ({Resolve_Valid, Branch_Taken} !== 2'b11 || Taken_Count !== 16'd3) begin
            n_fail++;
            $display("FAIL wait_result: got rv/bt=%b cnt=%0d expected 11 cnt=3", {Resolve_Valid, Branch_Taken}, Taken_Count);
        end
    endtask

    task automatic test_timeout();
        logic exp_stall [5];
        exp_stall = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tick();
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b100;
        Read_Data_1_ID = 32'hFFFF_FFFF; Forward_C_ID = 2'b11;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) Branch_Valid_ID = 1'b0;
            #1;
            n_checks++;
            if (Stall_ID !== exp_stall[i] || Resolve_Valid !== 1'b0 || Timeout_Err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_stall[%0d]: got stall=%b rv=%b to=%b expected stall=%b rv=0 to=0", i, Stall_ID, Resolve_Valid, Timeout_Err, exp_stall[i]);
            end
            tick();
        end
        n_checks++;
        if ({Resolve_Valid, Branch_Taken, Timeout_Err} !== 3'b101 || Taken_Count !== 16'd3) begin
            n_fail++;
            $display("FAIL timeout_result: got rv/bt/to=%b cnt=%0d expected 101 cnt=3", {Resolve_Valid, Branch_Taken, Timeout_Err}, Taken_Count);
        end
        tick();
        Forward_C_ID = 2'b00; Forward_D_ID = 2'b11;
        Branch_Valid_ID = 1'b1;
        n_checks++;
        if (Timeout_Err !== 1'b1 || Resolve_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: got to=%b rv=%b expected to=1 rv=0", Timeout_Err, Resolve_Valid);
        end
        #1;
        n_checks++;
        if (Stall_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL bltz_rt_unready_stall: got %b expected 0", Stall_ID);
        end
        tick();
        Branch_Valid_ID = 1'b0; Forward_D_ID = 2'b00;
        n_checks++;
        if ({Resolve_Valid, Branch_Taken, Timeout_Err} !== 3'b111 || Taken_Count !== 16'd4) begin
            n_fail++;
            $display("FAIL bltz_result: got rv/bt/to=%b cnt=%0d expected 111 cnt=4", {Resolve_Valid, Branch_Taken, Timeout_Err}, Taken_Count);
        end
    endtask

    task automatic test_flush();
        tick();
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b000;
        Read_Data_1_ID = 32'h9; Read_Data_2_ID = 32'h9; Fwd_Data_MEM = 32'h9;
        Forward_C_ID = 2'b11; Forward_D_ID = 2'b00;
        tick();
        Branch_Valid_ID = 1'b0;
        tick();
        Forward_C_ID = 2'b01; Flush_ID = 1'b1;
        #1;
        n_checks++;
        if (Stall_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %b expected 0", Stall_ID);
        end
        tick();
        Flush_ID = 1'b0; Forward_C_ID = 2'b11;
        n_checks++;
        if (Resolve_Valid !== 1'b0 || Taken_Count !== 16'd4 || Timeout_Err !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_result: got rv=%b cnt=%0d to=%b expected rv=0 cnt=4 to=1", Resolve_Valid, Taken_Count, Timeout_Err);
        end
        #1;
        n_checks++;
        if (Stall_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got stall=%b expected 0", Stall_ID);
        end
        tick();
        n_checks++;
        if (Resolve_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_late_pulse: got rv=%b expected 0", Resolve_Valid);
        end
        Forward_C_ID = 2'b00;
    endtask

    task automatic test_reset_mid_wait();
        tick();
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b000; Forward_C_ID = 2'b11;
        tick();
        Branch_Valid_ID = 1'b0;
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({Stall_ID, Resolve_Valid, Branch_Taken, Timeout_Err} !== 4'b0000 || Taken_Count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got s/rv/bt/to=%b cnt=%0d expected 0000 cnt=0", {Stall_ID, Resolve_Valid, Branch_Taken, Timeout_Err}, Taken_Count);
        end
        Forward_C_ID = 2'b00;
        Reset_n = 1'b1;
        tick();
        n_checks++;
        if (Resolve_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got rv=%b expected 0", Resolve_Valid);
        end
    endtask

    task automatic test_back_to_back_saturation();
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        Branch_Valid_ID = 1'b1; Branch_Op_ID = 3'b000;
        Read_Data_1_ID = 32'hA5A5_0001; Read_Data_2_ID = 32'hA5A5_0001;
        Forward_C_ID = 2'b00; Forward_D_ID = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) Branch_Valid_ID = 1'b0;
            n_checks++;
            if (Resolve_Valid !== 1'b1 || Taken_Count !== 16'(i + 1) || Taken_Count2 !== exp_sat[i]) begin
                n_fail++;
                $display("FAIL b2b_sat[%0d]: got rv=%b cnt=%0d cnt2=%0d expected rv=1 cnt=%0d cnt2=%0d", i, Resolve_Valid, Taken_Count, Taken_Count2, i + 1, exp_sat[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset_n = 1'b0; Flush_ID = 1'b0; Branch_Valid_ID = 1'b0; Branch_Op_ID = 3'b000;
        Read_Data_1_ID = '0; Read_Data_2_ID = '0; Fwd_Data_MEM = '0; Write_Data_WB = '0;
        Forward_C_ID = 2'b00; Forward_D_ID = 2'b00;
        test_reset();
        test_beq_regfile();
        test_forward_back_to_back();
        test_reserved();
        test_wait_ready();
        test_timeout();
        test_flush();
        test_reset_mid_wait();
        test_back_to_back_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_branch_resolve_unit.md
# id_branch_resolve_unit

Parametrised ID-stage branch resolver: selects each compare operand from register file, MEM forward or WB forward, evaluates one of six MIPS branch conditions, and returns a registered taken/not-taken result. Operands still in flight (e.g. load results) are handled by a wait FSM that stalls ID until both needed operands are forwardable, with a bounded wait and sticky timeout flag. Sits beside the ID register-file read port, feeding PC-select and IF/ID flush logic; forward selects come from the hazard unit.

## Interface
- DATA_WIDTH, 32, operand width
- MAX_WAIT, 4, max cycles in WAIT before timeout (1..255)
- CNT_WIDTH, 16, width of taken-branch counter
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Flush_ID  in  1  cancels the branch in ID (highest priority)
- Branch_Valid_ID  in  1  branch instruction present in ID
- Branch_Op_ID  in  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110/111 reserved
- Read_Data_1_ID, Read_Data_2_ID  in  DATA_WIDTH  register file operands rs, rt
- Fwd_Data_MEM  in  DATA_WIDTH  EX/MEM result
- Write_Data_WB  in  DATA_WIDTH  WB write data
- Forward_C_ID, Forward_D_ID  in  2  select for rs, rt: 00 regfile, 01 MEM, 10 WB, 11 not yet available
- Stall_ID  out  1  hold PC and IF/ID (combinational)
- Resolve_Valid  out  1  one-cycle pulse, result valid
- Branch_Taken  out  1  condition result, valid with Resolve_Valid
- Timeout_Err  out  1  sticky, set on wait timeout
- Taken_Count  out  CNT_WIDTH  saturating count of taken branches

## Operation
- FSM states: IDLE, WAIT.
- Operand A = mux(Forward_C_ID), operand B = mux(Forward_D_ID). Select 11 = not ready.
- Needed operands: BEQ/BNE need A and B; BLEZ/BGTZ/BLTZ/BGEZ need A only (B select ignored, even if 11). Reserved ops need none.
- Conditions: BEQ A==B; BNE A!=B; BLEZ A signed <= 0; BGTZ A signed > 0; BLTZ A[MSB]=1; BGEZ A[MSB]=0; reserved -> not taken. All DATA_WIDTH-bit, signed two's complement.
- IDLE: Branch_Valid_ID=1, needed operands ready -> register result (Resolve_Valid=1, Branch_Taken=cond next cycle), stay IDLE. Not ready -> capture Branch_Op_ID, wait counter=1, go WAIT.
- WAIT: op is the captured one; Branch_Op_ID ignored. Operands re-muxed every cycle. Ready -> register result, go IDLE. Not ready and counter==MAX_WAIT -> Timeout_Err<=1, result registered as not taken, go IDLE. Else counter+1.
- Stall_ID = (IDLE & Branch_Valid_ID & !ready) | (WAIT & !ready & counter<MAX_WAIT); 0 when Flush_ID=1.
- Flush_ID=1: no result pulse, go IDLE, counter cleared; overrides simultaneous ready or timeout. Timeout_Err and Taken_Count unaffected.
- Taken_Count increments on each Resolve_Valid with Branch_Taken=1; saturates at all-ones.
- Timeout_Err cleared only by reset.

## Timing
- Reset (async, Reset_n=0): state IDLE, counter 0, Resolve_Valid 0, Branch_Taken 0, Timeout_Err 0, Taken_Count 0; Stall_ID follows combinational definition (0 unless Branch_Valid_ID with unready operand in IDLE). Reset mid-WAIT discards the branch, no pulse.
- Ready branch at cycle N: Stall_ID=0 at N, Resolve_Valid/Branch_Taken at N+1 (latency 1).
- Unready at N, ready at N+k (k<=MAX_WAIT): Stall_ID=1 for cycles N..N+k-1, result pulse at N+k+1.
- Never ready: Stall_ID=1 for cycles N..N+MAX_WAIT-1, 0 at N+MAX_WAIT; Timeout_Err and not-taken pulse at N+MAX_WAIT+1.
- Back-to-back ready branches: one pulse per cycle, no bubbles.
- Branch_Taken holds last value when Resolve_Valid=0.

## Test plan
- Reset then BEQ, A=B=0x0000_1234, selects 00 -> Stall_ID=0, next cycle Resolve_Valid=1, Branch_Taken=1, Taken_Count=1.
- BNE, Forward_C=01 (MEM=0x5), Forward_D=10 (WB=0x5), regfile 0x0 -> not taken; then BGTZ A=0x8000_0000 -> not taken; BGEZ A=0x0 -> taken.
- BEQ with Forward_C=11 for 2 cycles then 01, MEM=regfile rt=0x7 -> Stall_ID high 2 cycles, taken pulse 1 cycle after select changes.
- BLTZ, Forward_C=11 for 6 cycles, MAX_WAIT=4 -> Stall_ID high 4 cycles, Timeout_Err=1 sticky, not-taken pulse; BLTZ with Forward_D=11 alone never stalls.
- Flush_ID asserted in WAIT on the cycle operands become ready -> no Resolve_Valid, FSM IDLE, Taken_Count unchanged; Reset_n low mid-WAIT -> all outputs 0 immediately.
- CNT_WIDTH=2, 5 taken branches -> Taken_Count saturates at 3.
